// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port among NCORES multicycle cores.
// Each access: one arbitration cycle, WAIT_CYCLES+1 busy cycles, one ack cycle.
module mem_arbiter #(
    parameter int unsigned NCORES      = 2,
    parameter int unsigned AW          = 32,
    parameter int unsigned DW          = 32,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCORES-1:0]    req,
    input  logic [NCORES-1:0]    we,
    input  logic [NCORES*AW-1:0] addr,
    input  logic [NCORES*DW-1:0] wdata,
    output logic [NCORES-1:0]    gnt,
    output logic [NCORES-1:0]    ack,
    output logic [DW-1:0]        rdata,
    output logic [NCORES-1:0]    stall,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [AW-1:0]        mem_addr,
    output logic [DW-1:0]        mem_wdata,
    input  logic [DW-1:0]        mem_rdata
);

    localparam int unsigned PW = (NCORES > 2) ? $clog2(NCORES) : 1;
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StResp
    } state_e;

    state_e            state_q, state_d;
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [NCORES-1:0] gnt_q, gnt_d;
    logic [NCORES-1:0] ack_q, ack_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic              we_lat_q, we_lat_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DW-1:0]     wdata_q, wdata_d;

    logic              found;
    logic [PW-1:0]     winner;
    logic [PW:0]       idx;

    // First requester scanning upward from the core after the last winner.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int unsigned i = 1; i <= NCORES; i++) begin
            idx = {1'b0, rr_ptr_q} + (PW+1)'(i);
            if (idx >= (PW+1)'(NCORES)) begin
                idx = idx - (PW+1)'(NCORES);
            end
            if (!found && req[idx[PW-1:0]]) begin
                found  = 1'b1;
                winner = idx[PW-1:0];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        gnt_d    = gnt_q;
        ack_d    = '0;
        rdata_d  = rdata_q;
        mem_en_d = mem_en_q;
        mem_we_d = 1'b0;
        we_lat_d = we_lat_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    state_d        = StBusy;
                    rr_ptr_d       = winner;
                    cnt_d          = CW'(WAIT_CYCLES);
                    gnt_d          = '0;
                    gnt_d[winner]  = 1'b1;
                    we_lat_d       = we[winner];
                    mem_we_d       = we[winner];
                    mem_en_d       = 1'b1;
                    addr_d         = addr[winner*AW +: AW];
                    wdata_d        = wdata[winner*DW +: DW];
                end
            end
            StBusy: begin
                if (cnt_q == '0) begin
                    state_d  = StResp;
                    mem_en_d = 1'b0;
                    ack_d    = gnt_q;
                    if (!we_lat_q) begin
                        rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            StResp: begin
                state_d = StIdle;
                gnt_d   = '0;
                addr_d  = '0;
                wdata_d = '0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            rr_ptr_q <= PW'(NCORES - 1);
            cnt_q    <= '0;
            gnt_q    <= '0;
            ack_q    <= '0;
            rdata_q  <= '0;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            we_lat_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
            mem_en_q <= mem_en_d;
            mem_we_q <= mem_we_d;
            we_lat_q <= we_lat_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign gnt       = gnt_q;
    assign ack       = ack_q;
    assign rdata     = rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign stall     = req & ~ack_q;

    // The port has a single owner, and only the owner is acknowledged.
    assert property (@(posedge clk) disable iff (reset) $onehot0(gnt_q));
    assert property (@(posedge clk) disable iff (reset) $onehot0(ack_q));
    assert property (@(posedge clk) disable iff (reset) (ack_q != '0) |-> (ack_q == gnt_q));

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: four builds (N/W = 2/1, 2/0, 2/3, 4/2) share one stimulus,
// each checked every cycle against a transaction-timeline model.
module tb_mem_arbiter;

    logic         clk;
    logic         reset;
    logic [3:0]   req_all;
    logic [3:0]   we_all;
    logic [127:0] addr_all;
    logic [127:0] wdata_all;
    logic [31:0]  mem_rdata;
    bit           run;
    int           checks;
    int           failures;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int last, input int n);
        for (int j = 1; j <= n; j++) begin
            if (r[(last + j) % n]) return (last + j) % n;
        end
        return -1;
    endfunction

    for (genvar g = 0; g < 4; g++) begin : gen_dut
        localparam int N = (g == 3) ? 4 : 2;
        localparam int W = (g == 0) ? 1 : (g == 1) ? 0 : (g == 2) ? 3 : 2;

        logic [N-1:0] gnt, ack, stall;
        logic [31:0]  rdata, mem_addr, mem_wdata;
        logic         mem_en, mem_we;

        mem_arbiter #(
            .NCORES     (N),
            .AW         (32),
            .DW         (32),
            .WAIT_CYCLES(W)
        ) dut (
            .clk      (clk),
            .reset    (reset),
            .req      (req_all[N-1:0]),
            .we       (we_all[N-1:0]),
            .addr     (addr_all[N*32-1:0]),
            .wdata    (wdata_all[N*32-1:0]),
            .gnt      (gnt),
            .ack      (ack),
            .rdata    (rdata),
            .stall    (stall),
            .mem_en   (mem_en),
            .mem_we   (mem_we),
            .mem_addr (mem_addr),
            .mem_wdata(mem_wdata),
            .mem_rdata(mem_rdata)
        );

        // m_k counts cycles since the grant edge: 1..W+1 busy, W+2 ack.
        bit          m_active, m_we;
        int          m_k, m_win, m_last, m_pick;
        logic [31:0] m_addr, m_wdata, m_rdata;
        logic [N-1:0] e_gnt, e_ack;
        logic         e_en, e_we;

        always_comb m_pick = pick(req_all, m_last, N);

        always @(posedge clk or posedge reset) begin
            if (reset) begin
                m_active <= 1'b0;
                m_k      <= 0;
                m_win    <= 0;
                m_last   <= N - 1;
                m_rdata  <= '0;
            end else if (!m_active) begin
                if (m_pick >= 0) begin
                    m_active <= 1'b1;
                    m_k      <= 1;
                    m_win    <= m_pick;
                    m_last   <= m_pick;
                    m_we     <= we_all[m_pick];
                    m_addr   <= addr_all[m_pick*32 +: 32];
                    m_wdata  <= wdata_all[m_pick*32 +: 32];
                end
            end else if (m_k == W + 2) begin
                m_active <= 1'b0;
                m_k      <= 0;
            end else begin
                if (m_k == W + 1 && !m_we) m_rdata <= mem_rdata;
                m_k <= m_k + 1;
            end
        end

        always_comb begin
            e_gnt = '0;
            e_ack = '0;
            e_en  = 1'b0;
            e_we  = 1'b0;
            if (m_active) begin
                e_gnt[m_win] = 1'b1;
                e_en         = (m_k <= W + 1);
                e_we         = (m_k == 1) && m_we;
                if (m_k == W + 2) e_ack[m_win] = 1'b1;
            end
        end

        always @(negedge clk) begin
            if (run) begin
                check($sformatf("g%0d.gnt", g), 64'(gnt), 64'(e_gnt));
                check($sformatf("g%0d.ack", g), 64'(ack), 64'(e_ack));
                check($sformatf("g%0d.mem_en", g), 64'(mem_en), 64'(e_en));
                check($sformatf("g%0d.mem_we", g), 64'(mem_we), 64'(e_we));
                check($sformatf("g%0d.stall", g), 64'(stall), 64'(req_all[N-1:0] & ~e_ack));
                check($sformatf("g%0d.rdata", g), 64'(rdata), 64'(m_rdata));
                if (e_en) begin
                    check($sformatf("g%0d.mem_addr", g), 64'(mem_addr), 64'(m_addr));
                    check($sformatf("g%0d.mem_wdata", g), 64'(mem_wdata), 64'(m_wdata));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] ack_seq [4];
    int         ack_t [4];
    int         n_ack;

    initial begin
        reset     = 1'b1;
        run       = 1'b0;
        req_all   = '0;
        we_all    = '0;
        addr_all  = '0;
        wdata_all = '0;
        mem_rdata = '0;
        checks    = 0;
        failures  = 0;
        repeat (3) @(posedge clk);
        #1;
        run = 1'b1;
        check("rst.gnt", 64'(gen_dut[0].gnt), 64'h0);
        check("rst.rdata", 64'(gen_dut[0].rdata), 64'h0);
        check("rst.mem_en", 64'(gen_dut[0].mem_en), 64'h0);
        check("rst.mem_addr", 64'(gen_dut[0].mem_addr), 64'h0);
        reset = 1'b0;
        tick();

        // Single read by core0.
        mem_rdata         = 32'hDEADBEEF;
        req_all           = 4'b0001;
        addr_all[0 +: 32] = 32'h40;
        tick();
        check("rd.gnt_c1", 64'(gen_dut[0].gnt), 64'h1);
        check("rd.en_c1", 64'(gen_dut[0].mem_en), 64'h1);
        check("rd.addr_c1", 64'(gen_dut[0].mem_addr), 64'h40);
        tick();
        check("rd.en_c2", 64'(gen_dut[0].mem_en), 64'h1);
        check("rd.ack_c2", 64'(gen_dut[0].ack), 64'h0);
        check("rd.w0_ack_c2", 64'(gen_dut[1].ack), 64'h1);
        check("rd.w0_rdata_c2", 64'(gen_dut[1].rdata), 64'hDEADBEEF);
        tick();
        check("rd.ack_c3", 64'(gen_dut[0].ack), 64'h1);
        check("rd.rdata_c3", 64'(gen_dut[0].rdata), 64'hDEADBEEF);
        check("rd.en_c3", 64'(gen_dut[0].mem_en), 64'h0);
        req_all = '0;
        tick();
        check("rd.gnt_c4", 64'(gen_dut[0].gnt), 64'h0);

        // Single write by core1.
        mem_rdata          = 32'hCAFEF00D;
        req_all            = 4'b0010;
        we_all             = 4'b0010;
        addr_all[32 +: 32] = 32'h80;
        wdata_all[32 +: 32] = 32'h12345678;
        tick();
        check("wr.gnt", 64'(gen_dut[0].gnt), 64'h2);
        check("wr.we_c1", 64'(gen_dut[0].mem_we), 64'h1);
        check("wr.addr", 64'(gen_dut[0].mem_addr), 64'h80);
        check("wr.wdata", 64'(gen_dut[0].mem_wdata), 64'h12345678);
        tick();
        check("wr.we_c2", 64'(gen_dut[0].mem_we), 64'h0);
        tick();
        check("wr.ack", 64'(gen_dut[0].ack), 64'h2);
        check("wr.rdata_kept", 64'(gen_dut[0].rdata), 64'hDEADBEEF);
        req_all = '0;
        we_all  = '0;
        repeat (6) tick();

        // Contention: both cores request continuously.
        for (int i = 0; i < 4; i++) begin
            ack_seq[i] = '0;
            ack_t[i]   = 0;
        end
        n_ack   = 0;
        req_all = 4'b0011;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (gen_dut[0].ack != '0 && n_ack < 4) begin
                ack_seq[n_ack] = gen_dut[0].ack;
                ack_t[n_ack]   = i;
                n_ack++;
            end
        end
        check("cont.count", 64'(n_ack), 64'd4);
        check("cont.ack0", 64'(ack_seq[0]), 64'h1);
        check("cont.ack1", 64'(ack_seq[1]), 64'h2);
        check("cont.ack2", 64'(ack_seq[2]), 64'h1);
        check("cont.ack3", 64'(ack_seq[3]), 64'h2);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("cont.gap%0d", i), 64'(ack_t[i+1] - ack_t[i]), 64'd4);
        end
        req_all = '0;
        repeat (6) tick();

        // Core0 drops req in its first busy cycle; core1 follows.
        req_all = 4'b0001;
        tick();
        check("drop.gnt_c1", 64'(gen_dut[0].gnt), 64'h1);
        req_all = 4'b0010;
        tick();
        tick();
        check("drop.ack_c3", 64'(gen_dut[0].ack), 64'h1);
        tick();
        tick();
        check("drop.gnt_c5", 64'(gen_dut[0].gnt), 64'h2);
        req_all = '0;
        repeat (6) tick();

        // Reset in the second busy cycle of the W=3 build.
        req_all = 4'b0001;
        tick();
        tick();
        reset   = 1'b1;
        req_all = 4'b0011;
        #1;
        check("rstb.gnt", 64'(gen_dut[2].gnt), 64'h0);
        check("rstb.mem_en", 64'(gen_dut[2].mem_en), 64'h0);
        check("rstb.mem_we", 64'(gen_dut[2].mem_we), 64'h0);
        check("rstb.ack", 64'(gen_dut[2].ack), 64'h0);
        tick();
        reset = 1'b0;
        tick();
        check("rstb.w3_gnt", 64'(gen_dut[2].gnt), 64'h1);
        check("rstb.w1_gnt", 64'(gen_dut[0].gnt), 64'h1);
        req_all = '0;
        repeat (6) tick();

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 99) < 20) req_all[i] = ~req_all[i];
            end
            we_all    = 4'($urandom);
            addr_all  = {$urandom, $urandom, $urandom, $urandom};
            wdata_all = {$urandom, $urandom, $urandom, $urandom};
            mem_rdata = $urandom;
            reset     = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 1'b0;
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shared-memory arbiter that sits directly downstream of each core's multicycle controller and datapath.
- Accepts one memory request per core (address, write enable, write data, taken from each core's AdrSrc-muxed address and MemWrite).
- Grants a single unified memory port round-robin and returns read data with a per-core ack.
- Drives a per-core stall so each controller's FSM holds in its memory state until the access completes.

Parameters:
- NCORES, 2, number of requesting cores (2..8).
- AW, 32, address width.
- DW, 32, data width.
- WAIT_CYCLES, 1, extra memory latency cycles beyond the first (0..15).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  NCORES  per-core access request; held high until ack.
- we  input  NCORES  per-core write enable (1 = store, 0 = load/fetch).
- addr  input  NCORES*AW  per-core address; core i occupies bits [i*AW +: AW].
- wdata  input  NCORES*DW  per-core write data, packed the same way.
- gnt  output  NCORES  one-hot, registered; high for core owning the port, from grant through ack.
- ack  output  NCORES  one-hot, one-cycle pulse on access completion.
- rdata  output  DW  registered read data, broadcast to all cores, valid in the ack cycle.
- stall  output  NCORES  stall[i] = req[i] & ~ack[i] (combinational).
- mem_en  output  1  memory enable.
- mem_we  output  1  memory write strobe.
- mem_addr  output  AW  latched winner address.
- mem_wdata  output  DW  latched winner write data.
- mem_rdata  input  DW  memory read data, valid on the last BUSY cycle.

Behaviour:
- Reset (asynchronous): state=IDLE, rr_ptr=NCORES-1, gnt=0, ack=0, rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, wait counter=0.
- States: IDLE, BUSY, RESP.
- IDLE:
  - If any req is high, choose the winner: first requesting core scanning upward from rr_ptr+1 modulo NCORES.
  - Register gnt[winner]=1, latch addr/we/wdata of the winner, set rr_ptr=winner, load counter=WAIT_CYCLES, go to BUSY.
  - No req: remain in IDLE, all outputs 0.
- BUSY:
  - mem_en=1 throughout; mem_addr and mem_wdata are stable from latched values.
  - mem_we=latched we in the first BUSY cycle only.
  - Counter decrements each cycle. In the cycle where counter==0, capture mem_rdata into rdata (reads only; rdata holds its old value on writes), then go to RESP.
  - BUSY lasts WAIT_CYCLES+1 cycles.
- RESP:
  - ack[winner]=1 for exactly this one cycle; gnt stays high. Next cycle gnt=0, go to IDLE.
- Latency: req rising in an IDLE cycle at edge N gives gnt at N+1, BUSY for N+1..N+1+W, and ack at N+2+W. With W=1, ack comes 3 cycles after req is sampled.
- Back-to-back: a core keeping req high after its ack is treated as a new request, arbitrated in the following IDLE cycle. There is one IDLE bubble minimum between transactions.
- Fairness: with all cores requesting continuously, grants rotate 0,1,...,NCORES-1,0,...
- Simultaneous requests in IDLE: exactly one winner per rr_ptr rule; losers keep stall high.
- req dropped mid-transaction: the transaction still completes, including memory write and ack pulse. Inputs are not re-sampled after grant.
- Input changes on addr/we/wdata after grant are ignored until the next arbitration.
- Reset asserted in BUSY or RESP: immediately return to IDLE. Any in-flight write may have been strobed; no ack is issued.
- gnt and ack are always one-hot or zero; never more than one bit set.

Test Plan:
- Single read, W=1: core0 req=1, we=0, addr=0x40; mem_rdata=0xDEADBEEF in the last BUSY cycle -> gnt[0] at cycle 1, mem_en at cycles 1-2, ack[0] plus rdata=0xDEADBEEF at cycle 3, stall[0] high at cycles 0-2.
- Single write: core1 req=1, we=1, addr=0x80, wdata=0x12345678 -> mem_we high for exactly one cycle with mem_addr=0x80 and mem_wdata=0x12345678; ack[1] once; rdata unchanged.
- Contention, NCORES=2: both req high from cycle 0 and held, re-requesting after ack -> grant order 0,1,0,1; each ack spaced W+3 cycles apart; never two gnt bits high.
- Request drop: core0 deasserts req in its first BUSY cycle -> access completes, ack[0] still pulses once, next grant goes to core1 if it is requesting.
- Reset mid-BUSY with W=3: assert reset in the 2nd BUSY cycle -> all outputs 0 in that cycle; after release with core1 requesting, core0 wins first because rr_ptr=NCORES-1.
- WAIT_CYCLES=0 build: read request -> one BUSY cycle, ack 2 cycles after req is sampled, rdata captured correctly.
